// File: rtl/alu_issue_unit_if.sv
// Instruction, ALU and debug signals between an issuing agent and alu_issue_unit.
// The master modport is the issuer/ALU side; the slave modport is the unit.
interface alu_issue_unit_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [2:0] dest;
  logic [2:0] src1;
  logic [2:0] src2;
  logic [7:0] imm;
  logic       imm_sel;
  logic [7:0] alu_data1;
  logic [7:0] alu_data2;
  logic [2:0] alu_select;
  logic [7:0] alu_result;
  logic       done;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  modport master (
    output instr_valid, opcode, dest, src1, src2, imm, imm_sel, alu_result, dbg_addr,
    input  instr_ready, alu_data1, alu_data2, alu_select, done, dbg_data
  );

  modport slave (
    input  instr_valid, opcode, dest, src1, src2, imm, imm_sel, alu_result, dbg_addr,
    output instr_ready, alu_data1, alu_data2, alu_select, done, dbg_data
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Issues one instruction at a time to an external ALU from an 8x8 register file,
// waits an opcode-dependent number of cycles, then writes the ALU result back.
module alu_issue_unit #(
  parameter int unsigned ADD_WAIT   = 2,
  parameter int unsigned LOGIC_WAIT = 1
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_unit_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  regs_r [8];
  logic [3:0]  wait_cnt_r;
  logic [2:0]  dest_r;
  logic [7:0]  alu_data1_r;
  logic [7:0]  alu_data2_r;
  logic [2:0]  alu_select_r;
  logic        done_r;
  logic        accept_s;
  logic        writeback_s;

  // Reserved opcodes still take one cycle so the FSM always returns to IDLE.
  function automatic logic [3:0] wait_for(input logic [2:0] op);
    logic [3:0] w;
    case (op)
      3'b001:                 w = 4'(ADD_WAIT);
      3'b000, 3'b010, 3'b011: w = 4'(LOGIC_WAIT);
      default:                w = 4'd1;
    endcase
    return w;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus the accept and write-back strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    writeback_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.instr_valid) begin
          accept_s     = 1'b1;
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: begin
        if (wait_cnt_r == 4'd1) begin
          writeback_s  = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = EXEC;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Operand latch, wait countdown, register write-back and DONE pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= 8'h00;
      end
      alu_data1_r  <= 8'h00;
      alu_data2_r  <= 8'h00;
      alu_select_r <= 3'b000;
      dest_r       <= 3'b000;
      wait_cnt_r   <= 4'd0;
      done_r       <= 1'b0;
    end else begin
      done_r <= writeback_s;
      if (accept_s) begin
        alu_data1_r  <= regs_r[bus.src1];
        alu_data2_r  <= bus.imm_sel ? bus.imm : regs_r[bus.src2];
        alu_select_r <= bus.opcode;
        dest_r       <= bus.dest;
        wait_cnt_r   <= wait_for(bus.opcode);
      end else if (writeback_s) begin
        regs_r[dest_r] <= bus.alu_result;
        wait_cnt_r     <= 4'd0;
      end else if (state_r == EXEC) begin
        wait_cnt_r <= wait_cnt_r - 4'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  assign bus.instr_ready = (state_r == IDLE);
  assign bus.alu_data1   = alu_data1_r;
  assign bus.alu_data2   = alu_data2_r;
  assign bus.alu_select  = alu_select_r;
  assign bus.done        = done_r;
  assign bus.dbg_data    = regs_r[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit with default wait parameters.
module tb_alu_issue_unit;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  alu_issue_unit_if bus ();

  alu_issue_unit #(.ADD_WAIT(2), .LOGIC_WAIT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [2:0] addr);
    bus.dbg_addr = addr;
    #1;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1,
                           input logic [2:0] s2, input logic [7:0] im, input logic isel);
    bus.opcode  = op;
    bus.dest    = d;
    bus.src1    = s1;
    bus.src2    = s2;
    bus.imm     = im;
    bus.imm_sel = isel;
  endtask

  // Issue one instruction and run it to write-back (w cycles after accept).
  task automatic run_op(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [7:0] im, input logic isel,
                        input logic [7:0] res, input int w);
    set_instr(op, d, s1, s2, im, isel);
    bus.alu_result  = res;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < w; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    for (int a = 0; a < 8; a++) begin
      peek(3'(a));
      total_cnt++; if (bus.dbg_data !== 8'h00) $display("FAIL reset_reg%0d: got %h want 00", a, bus.dbg_data); else pass_cnt++;
    end
    total_cnt++; if (bus.instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.instr_ready); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.alu_select !== 3'b000) $display("FAIL reset_select: got %b want 000", bus.alu_select); else pass_cnt++;
    total_cnt++; if (bus.alu_data1 !== 8'h00 || bus.alu_data2 !== 8'h00) $display("FAIL reset_data: got %h/%h want 00/00", bus.alu_data1, bus.alu_data2); else pass_cnt++;
  endtask

  task automatic test_forward();
    set_instr(3'b000, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1);
    bus.alu_result  = 8'h05;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    total_cnt++; if (bus.alu_select !== 3'b000) $display("FAIL fwd_select: got %b want 000", bus.alu_select); else pass_cnt++;
    total_cnt++; if (bus.alu_data2 !== 8'h05) $display("FAIL fwd_data2: got %h want 05", bus.alu_data2); else pass_cnt++;
    total_cnt++; if (bus.instr_ready !== 1'b0) $display("FAIL fwd_busy: got %b want 0", bus.instr_ready); else pass_cnt++;
    step();
    peek(3'd1);
    total_cnt++; if (bus.dbg_data !== 8'h05) $display("FAIL fwd_reg1: got %h want 05", bus.dbg_data); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b1) $display("FAIL fwd_done: got %b want 1", bus.done); else pass_cnt++;
    total_cnt++; if (bus.instr_ready !== 1'b1) $display("FAIL fwd_ready: got %b want 1", bus.instr_ready); else pass_cnt++;
    step();
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL fwd_done_pulse: got %b want 0", bus.done); else pass_cnt++;
  endtask

  task automatic test_add();
    set_instr(3'b001, 3'd2, 3'd1, 3'd1, 8'h00, 1'b0);
    bus.alu_result  = 8'h0A;
    bus.instr_valid = 1'b1;
    step();
    // Keep valid high with a different instruction while busy.
    set_instr(3'b011, 3'd3, 3'd0, 3'd0, 8'h77, 1'b1);
    total_cnt++; if (bus.alu_data1 !== 8'h05 || bus.alu_data2 !== 8'h05) $display("FAIL add_operands: got %h/%h want 05/05", bus.alu_data1, bus.alu_data2); else pass_cnt++;
    total_cnt++; if (bus.alu_select !== 3'b001) $display("FAIL add_select: got %b want 001", bus.alu_select); else pass_cnt++;
    step();
    peek(3'd2);
    total_cnt++; if (bus.done !== 1'b0 || bus.dbg_data !== 8'h00) $display("FAIL add_early: done %b reg2 %h want 0/00", bus.done, bus.dbg_data); else pass_cnt++;
    total_cnt++; if (bus.instr_ready !== 1'b0) $display("FAIL add_busy: got %b want 0", bus.instr_ready); else pass_cnt++;
    step();
    bus.instr_valid = 1'b0;
    peek(3'd2);
    total_cnt++; if (bus.dbg_data !== 8'h0A) $display("FAIL add_reg2: got %h want 0a", bus.dbg_data); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b1) $display("FAIL add_done: got %b want 1", bus.done); else pass_cnt++;
    total_cnt++; if (bus.alu_select !== 3'b001 || bus.alu_data2 !== 8'h05) $display("FAIL add_hold: sel %b d2 %h want 001/05", bus.alu_select, bus.alu_data2); else pass_cnt++;
    peek(3'd3);
    total_cnt++; if (bus.dbg_data !== 8'h00) $display("FAIL add_ignored: reg3 %h want 00", bus.dbg_data); else pass_cnt++;
    step();
    total_cnt++; if (bus.done !== 1'b0 || bus.instr_ready !== 1'b1) $display("FAIL add_after: done %b ready %b want 0/1", bus.done, bus.instr_ready); else pass_cnt++;
  endtask

  task automatic test_wrap_and_logic();
    run_op(3'b000, 3'd3, 3'd0, 3'd0, 8'hFF, 1'b1, 8'hFF, 1);
    run_op(3'b000, 3'd4, 3'd0, 3'd0, 8'h01, 1'b1, 8'h01, 1);
    run_op(3'b000, 3'd5, 3'd0, 3'd0, 8'h5A, 1'b1, 8'h5A, 1);
    set_instr(3'b001, 3'd5, 3'd3, 3'd4, 8'h00, 1'b0);
    bus.alu_result  = 8'h00;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    total_cnt++; if (bus.alu_data1 !== 8'hFF || bus.alu_data2 !== 8'h01) $display("FAIL wrap_operands: got %h/%h want ff/01", bus.alu_data1, bus.alu_data2); else pass_cnt++;
    step();
    step();
    peek(3'd5);
    total_cnt++; if (bus.dbg_data !== 8'h00) $display("FAIL wrap_reg5: got %h want 00", bus.dbg_data); else pass_cnt++;
    // AND with immediate into reg0 completes after one cycle.
    set_instr(3'b010, 3'd0, 3'd3, 3'd0, 8'h0F, 1'b1);
    bus.alu_result  = 8'h0F;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    total_cnt++; if (bus.alu_data1 !== 8'hFF || bus.alu_data2 !== 8'h0F || bus.alu_select !== 3'b010) $display("FAIL and_issue: got %h/%h/%b want ff/0f/010", bus.alu_data1, bus.alu_data2, bus.alu_select); else pass_cnt++;
    step();
    peek(3'd0);
    total_cnt++; if (bus.dbg_data !== 8'h0F || bus.done !== 1'b1) $display("FAIL and_wb: reg0 %h done %b want 0f/1", bus.dbg_data, bus.done); else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    set_instr(3'b000, 3'd1, 3'd0, 3'd0, 8'h11, 1'b1);
    bus.alu_result  = 8'h11;
    bus.instr_valid = 1'b1;
    step();
    set_instr(3'b011, 3'd2, 3'd0, 3'd0, 8'h22, 1'b1);
    step();
    total_cnt++; if (bus.done !== 1'b1 || bus.alu_select !== 3'b000) $display("FAIL b2b_first: done %b sel %b want 1/000", bus.done, bus.alu_select); else pass_cnt++;
    bus.alu_result = 8'h22;
    step();
    bus.instr_valid = 1'b0;
    total_cnt++; if (bus.alu_data2 !== 8'h22 || bus.alu_select !== 3'b011 || bus.done !== 1'b0) $display("FAIL b2b_second_issue: d2 %h sel %b done %b want 22/011/0", bus.alu_data2, bus.alu_select, bus.done); else pass_cnt++;
    step();
    peek(3'd2);
    total_cnt++; if (bus.dbg_data !== 8'h22 || bus.done !== 1'b1) $display("FAIL b2b_second_wb: reg2 %h done %b want 22/1", bus.dbg_data, bus.done); else pass_cnt++;
    step();
  endtask

  task automatic test_reserved();
    run_op(3'b000, 3'd7, 3'd0, 3'd0, 8'h33, 1'b1, 8'h33, 1);
    peek(3'd7);
    total_cnt++; if (bus.dbg_data !== 8'h33) $display("FAIL rsv_preload: got %h want 33", bus.dbg_data); else pass_cnt++;
    set_instr(3'b100, 3'd7, 3'd1, 3'd2, 8'h00, 1'b0);
    bus.alu_result  = 8'h00;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    total_cnt++; if (bus.alu_select !== 3'b100 || bus.done !== 1'b0) $display("FAIL rsv_issue: sel %b done %b want 100/0", bus.alu_select, bus.done); else pass_cnt++;
    step();
    peek(3'd7);
    total_cnt++; if (bus.dbg_data !== 8'h00 || bus.done !== 1'b1 || bus.instr_ready !== 1'b1) $display("FAIL rsv_wb: reg7 %h done %b ready %b want 00/1/1", bus.dbg_data, bus.done, bus.instr_ready); else pass_cnt++;
    step();
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL rsv_done_once: got %b want 0", bus.done); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    run_op(3'b000, 3'd6, 3'd0, 3'd0, 8'h44, 1'b1, 8'h44, 1);
    set_instr(3'b001, 3'd6, 3'd6, 3'd6, 8'h00, 1'b0);
    bus.alu_result  = 8'h99;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    peek(3'd6);
    total_cnt++; if (bus.dbg_data !== 8'h00) $display("FAIL abort_reg6: got %h want 00", bus.dbg_data); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0 || bus.instr_ready !== 1'b1) $display("FAIL abort_state: done %b ready %b want 0/1", bus.done, bus.instr_ready); else pass_cnt++;
    total_cnt++; if (bus.alu_select !== 3'b000 || bus.alu_data1 !== 8'h00) $display("FAIL abort_outs: sel %b d1 %h want 000/00", bus.alu_select, bus.alu_data1); else pass_cnt++;
    step();
    peek(3'd6);
    total_cnt++; if (bus.done !== 1'b0 || bus.dbg_data !== 8'h00) $display("FAIL abort_late_wb: done %b reg6 %h want 0/00", bus.done, bus.dbg_data); else pass_cnt++;
    // Reset also wins over an accept on the same edge.
    set_instr(3'b000, 3'd2, 3'd0, 3'd0, 8'h66, 1'b1);
    bus.alu_result  = 8'h66;
    bus.instr_valid = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    total_cnt++; if (bus.instr_ready !== 1'b1 || bus.alu_data2 !== 8'h00) $display("FAIL reset_prio: ready %b d2 %h want 1/00", bus.instr_ready, bus.alu_data2); else pass_cnt++;
    step();
    peek(3'd2);
    total_cnt++; if (bus.dbg_data !== 8'h00 || bus.done !== 1'b0) $display("FAIL reset_prio_wb: reg2 %h done %b want 00/0", bus.dbg_data, bus.done); else pass_cnt++;
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    reset           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.alu_result  = 8'h00;
    bus.dbg_addr    = 3'd0;
    set_instr(3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0);
    test_reset();
    test_forward();
    test_add();
    test_wrap_and_logic();
    test_back_to_back();
    test_reserved();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
